// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder: default operand width and
// the controller state encoding.
// ---------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int unsigned SA_DEFAULT_WIDTH = 8;

    // Controller states, binary encoded.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sa_state_e;

endpackage : serial_adder_pkg

// File: rtl/Full_Adder.sv
// ---------------------------------------------------------------------------
// Full_Adder
// One-bit full adder cell.
// Ports:
//   A, B   - addend bits
//   Cin    - carry in
//   COUT   - carry out
//   SUM    - sum bit
// ---------------------------------------------------------------------------
module Full_Adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic COUT,
    output logic SUM
);

    assign SUM  = A ^ B ^ Cin;
    assign COUT = (A & B) | (Cin & (A ^ B));

endmodule : Full_Adder

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
// Bit-serial adder: computes A + B + Cin, one bit per clock, LSB first,
// through a single full-adder cell.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start_i  - begin an addition (honoured only when idle)
//   a_i/b_i  - operands, captured when start is accepted
//   cin_i    - carry in, captured when start is accepted
//   busy_o   - operation in progress (SHIFT or DONE)
//   done_o   - one-cycle pulse: new result on sum_o/cout_o
//   sum_o    - result, A + B + Cin modulo 2^WIDTH
//   cout_o   - carry out of the MSB
// ---------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int unsigned        CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    sa_state_e          state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   psum_shift;

    // Single bit cell fed from the operand LSBs and the running carry.
    Full_Adder u_fa (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .Cin  (carry_q),
        .COUT (fa_cout),
        .SUM  (fa_sum)
    );

    // New sum bit enters at the MSB so the result is aligned after WIDTH shifts.
    assign psum_shift = {fa_sum, psum_q[WIDTH-1:1]};

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SHIFT;
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = cin_i;
                    cnt_d   = '0;
                    psum_d  = '0;
                end
            end
            ST_SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_cout;
                psum_d  = psum_shift;
                if (cnt_q == CNT_LAST) begin
                    // Counter is held on the last bit so it never wraps.
                    state_d = ST_DONE;
                    sum_d   = psum_shift;
                    cout_d  = fa_cout;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Pulse is registered on leaving DONE, one cycle after the result load.
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
// Scoreboard bench for serial_adder: an 8-bit instance driven with directed
// vectors and a 4-bit instance swept over every A, B, Cin combination.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        int         acc;
    } exp8_t;

    typedef struct {
        logic [3:0] sum;
        logic       cout;
        int         acc;
    } exp4_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    logic [7:0] last_sum8 = 8'h00;

    exp8_t      q8[$];
    exp4_t      q4[$];
    exp8_t      e8;
    exp4_t      e4;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start8),
        .a_i     (a8),
        .b_i     (b8),
        .cin_i   (cin8),
        .busy_o  (busy8),
        .done_o  (done8),
        .sum_o   (sum8),
        .cout_o  (cout8)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start4),
        .a_i     (a4),
        .b_i     (b4),
        .cin_i   (cin4),
        .busy_o  (busy4),
        .done_o  (done4),
        .sum_o   (sum4),
        .cout_o  (cout4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Hand-computed 8-bit vectors: a, b, cin, sum, cout.
    function automatic vec_t vec(input int i);
        case (i)
            0:       return '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0};
            1:       return '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
            2:       return '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
            3:       return '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
            4:       return '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
            5:       return '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
            6:       return '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
            7:       return '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
            8:       return '{8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0};
            default: return '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        endcase
    endfunction

    // Called at a negedge with the 8-bit DUT idle; returns at the negedge
    // after the DONE pulse so the next call is accepted back-to-back.
    task automatic op8(input vec_t v, input bit hold_start);
        exp8_t e;
        a8     = v.a;
        b8     = v.b;
        cin8   = v.cin;
        start8 = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                e.sum  = v.sum;
                e.cout = v.cout;
                e.acc  = cyc;
                q8.push_back(e);
                if (!hold_start) start8 = 1'b0;
            end
            if (i <= 8) chk("sum8_stable", sum8, last_sum8);
            if (i < 10) begin
                a8   = 8'($urandom);
                b8   = 8'($urandom);
                cin8 = 1'($urandom);
            end
        end
        last_sum8 = v.sum;
    endtask

    // 8-bit monitor.
    always @(negedge clk) begin
        if (rst_n && done8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done8_unexpected: got done with no pending op, required none (cycle %0d)", cyc);
            end else begin
                e8 = q8.pop_front();
                chk("sum8", sum8, e8.sum);
                chk("cout8", cout8, e8.cout);
                chk("latency8", cyc - e8.acc, 9);
            end
        end
    end

    // 4-bit monitor.
    always @(negedge clk) begin
        if (rst_n && done4) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done4_unexpected: got done with no pending op, required none (cycle %0d)", cyc);
            end else begin
                e4 = q4.pop_front();
                chk("sum4", sum4, e4.sum);
                chk("cout4", cout4, e4.cout);
                chk("latency4", cyc - e4.acc, 5);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] r4;
        exp4_t      e;

        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_sum8",  sum8,  0);
        chk("rst_cout8", cout8, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_sum4",  sum4,  0);

        // Start is presented with the reset release and must be taken on the first edge.
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) op8(vec(i), 1'b0);

        // START held high: one acceptance every 10 cycles.
        op8(vec(3), 1'b1);
        op8(vec(6), 1'b1);
        op8(vec(9), 1'b1);
        start8 = 1'b0;

        // Abort mid-operation with reset.
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_sum8",  sum8,  0);
        chk("abort_cout8", cout8, 0);
        chk("abort_busy8", busy8, 0);
        chk("abort_done8", done8, 0);
        last_sum8 = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_idle_busy8", busy8, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        op8('{8'h10, 8'h20, 1'b0, 8'h30, 1'b0}, 1'b0);

        // Exhaustive 4-bit sweep against a reference sum.
        for (int n = 0; n < 512; n++) begin
            a4     = 4'(n);
            b4     = 4'(n >> 4);
            cin4   = 1'(n >> 8);
            start4 = 1'b1;
            r4     = 5'(a4) + 5'(b4) + 5'(cin4);
            @(posedge clk);
            for (int i = 1; i <= 6; i++) begin
                @(negedge clk);
                if (i == 1) begin
                    e.sum  = r4[3:0];
                    e.cout = r4[4];
                    e.acc  = cyc;
                    q4.push_back(e);
                    start4 = 1'b0;
                end
            end
        end

        repeat (12) @(negedge clk);
        chk("pending8", q8.size(), 0);
        chk("pending4", q4.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits, legal range 2..32.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 START  input  1  request to begin one addition; sampled only in IDLE.
REQ-005 A_IN  input  WIDTH  operand A; captured when START is accepted.
REQ-006 B_IN  input  WIDTH  operand B; captured when START is accepted.
REQ-007 CIN_IN  input  1  carry-in; captured when START is accepted.
REQ-008 BUSY  output  1  high while an addition is in progress (SHIFT or DONE state).
REQ-009 DONE  output  1  one-cycle pulse marking a valid new result.
REQ-010 SUM_OUT  output  WIDTH  result register, A+B+Cin modulo 2^WIDTH.
REQ-011 COUT_OUT  output  1  carry-out of the MSB position.

Function
REQ-012 States SHALL be IDLE, SHIFT and DONE, binary-encoded.
REQ-013 IDLE with START=1 SHALL transition to SHIFT and load A_IN, B_IN into shift registers, CIN_IN into the carry flop, and 0 into the bit counter.
REQ-014 IDLE with START=0 SHALL remain in IDLE with all registers held.
REQ-015 Each SHIFT cycle SHALL add A_reg[0], B_reg[0] and carry through one full-adder cell, write SUM into the MSB of a right-shifting partial-sum register, latch COUT into carry, shift A_reg/B_reg right by one, and increment the counter.
REQ-016 Operands SHALL be processed LSB first; exactly WIDTH SHIFT cycles SHALL occur per operation.
REQ-017 The SHIFT cycle with counter = WIDTH-1 SHALL transition to DONE and load SUM_OUT with the completed partial sum and COUT_OUT with that cycle's COUT.
REQ-018 DONE SHALL last exactly one cycle, with DONE=1, then return to IDLE unconditionally.
REQ-019 Latency: if START is sampled at edge 0, DONE SHALL be high between edges WIDTH+1 and WIDTH+2 (9 cycles after acceptance for WIDTH=8).
REQ-020 SUM_OUT/COUT_OUT SHALL remain stable from DONE until the next DONE and SHALL NOT change during SHIFT.
REQ-021 START in SHIFT or DONE SHALL be ignored with no queuing; a START in the cycle after DONE (IDLE) SHALL be accepted, giving a throughput of one operation per WIDTH+2 cycles.
REQ-022 Counter width SHALL be ceil(log2(WIDTH)) bits; the counter SHALL NOT wrap within one operation.
REQ-023 Operand changes on A_IN/B_IN/CIN_IN after acceptance SHALL NOT affect the result in progress.

Reset
REQ-024 RST_N low SHALL immediately force IDLE and clear BUSY, DONE, SUM_OUT, COUT_OUT, the shift registers, carry and counter to 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation; no DONE pulse SHALL follow for that operation.
REQ-026 After RST_N deasserts, START SHALL be honoured on the first rising edge.

Structure
REQ-027 State encodings (IDLE=0, SHIFT=1, DONE=2) and the default WIDTH SHALL live in shared package serial_adder_pkg.
REQ-028 The bit cell SHALL be one instance of the existing Full_Adder sub-module (ports A, B, Cin, COUT, SUM); no other sub-modules.

Verification
REQ-029 WIDTH=8, A=0x05, B=0x03, Cin=0, START pulse -> DONE exactly 9 cycles later, SUM_OUT=0x08, COUT_OUT=0.
REQ-030 A=0xFF, B=0x01, Cin=0 -> SUM_OUT=0x00, COUT_OUT=1; then A=0xFF, B=0xFF, Cin=1 -> SUM_OUT=0xFF, COUT_OUT=1.
REQ-031 START held high continuously with changing operands -> operations spaced 10 cycles apart, each result matching the operands captured at its acceptance edge.
REQ-032 RST_N pulsed low at SHIFT cycle 4 of A=0xAA, B=0x55 -> outputs 0 immediately, no DONE; a following START of 0x10+0x20 -> 0x30 with COUT_OUT=0.
REQ-033 WIDTH=4, exhaustive A, B, Cin (512 cases) against reference model -> all SUM_OUT/COUT_OUT match, DONE once per operation.
REQ-034 Operands changed every cycle during SHIFT -> result unchanged from the captured operands; SUM_OUT stable throughout SHIFT.
